// File: rtl/sub_pkg.sv
// rtl/sub_pkg.sv - shared types and elaboration helpers for serial_subtractor_n
// Purpose: FSM state encoding, digit-count / counter-width derivation and the
// WIDTH-divisible-by-DIGIT check used by the serial subtractor.
// Ports: none (package).
package sub_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_NEG  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  // Number of digit steps needed to cover the operand.
  function automatic int num_digits(input int width, input int digit);
    return (digit > 0) ? (width / digit) : 1;
  endfunction

  // Counter must index digits 0..n-1; keep at least one bit.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic bit digit_ok(input int width, input int digit);
    return (digit > 0) && (width > 0) && ((width % digit) == 0);
  endfunction

endpackage

// File: rtl/digit_sub.sv
// rtl/digit_sub.sv - combinational DIGIT-bit subtractor with borrow
// Purpose: diff = x - y - bin (mod 2^DIGIT), bout = 1 when the result underflows.
// Ports: x, y [DIGIT-1:0] operands; bin borrow in; diff [DIGIT-1:0]; bout borrow out.
module digit_sub #(
  parameter int DIGIT = 2
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             bin,
  output logic [DIGIT-1:0] diff,
  output logic             bout
);

  logic [DIGIT:0] full;

  // One extra bit captures the borrow as the sign of the widened difference.
  assign full = {1'b0, x} - {1'b0, y} - {{DIGIT{1'b0}}, bin};
  assign diff = full[DIGIT-1:0];
  assign bout = full[DIGIT];

endmodule

// File: rtl/serial_subtractor_n.sv
// rtl/serial_subtractor_n.sv - digit-serial unsigned subtractor with valid/ready handshakes
// Purpose: accepts a, b in IDLE, subtracts DIGIT bits per cycle LSB first,
// presents d and bout in DONE until the consumer accepts.
// Option macro SERIAL_SUB_ABS_DIFF_EN: when a < b, a NEG pass negates d so d = |a - b|.
// Ports: clk, rst_n (async, active low); in_valid/in_ready, a, b [WIDTH-1:0] operand side;
//        out_valid/out_ready, d [WIDTH-1:0], bout result side.
module serial_subtractor_n
  import sub_pkg::*;
#(
  parameter int WIDTH = 6,
  parameter int DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] d,
  output logic             bout
);

  localparam int N  = num_digits(WIDTH, DIGIT);
  localparam int CW = cnt_width(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  if (!digit_ok(WIDTH, DIGIT)) begin : g_bad_digit
    $error("serial_subtractor_n: WIDTH must be a positive multiple of DIGIT");
  end

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [WIDTH-1:0]  d_q, d_d;
  logic              borrow_q, borrow_d;
  logic              bout_q, bout_d;
  logic [CW-1:0]     cnt_q, cnt_d;

  logic [DIGIT-1:0]  x_mux, y_mux, dig_diff;
  logic              dig_bout;

  // Operands are shifted right each step so the active digit is always the LSBs.
  // NEG reuses the same subtractor as 0 - d, consuming d from its LSBs.
  always_comb begin
    x_mux = a_q[DIGIT-1:0];
    y_mux = b_q[DIGIT-1:0];
    if (state_q == S_NEG) begin
      x_mux = '0;
      y_mux = d_q[DIGIT-1:0];
    end
  end

  digit_sub #(.DIGIT(DIGIT)) u_digit_sub (
    .x    (x_mux),
    .y    (y_mux),
    .bin  (borrow_q),
    .diff (dig_diff),
    .bout (dig_bout)
  );

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    d_d      = d_q;
    borrow_d = borrow_q;
    bout_d   = bout_q;
    cnt_d    = cnt_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d      = a;
          b_d      = b;
          borrow_d = 1'b0;
          bout_d   = 1'b0;
          cnt_d    = '0;
          state_d  = S_RUN;
        end
      end

      S_RUN: begin
        a_d      = a_q >> DIGIT;
        b_d      = b_q >> DIGIT;
        // New digit enters at the MSB end; after N steps d is fully aligned.
        d_d      = (d_q >> DIGIT) | (WIDTH'(dig_diff) << (WIDTH - DIGIT));
        borrow_d = dig_bout;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          bout_d   = dig_bout;
          borrow_d = 1'b0;
          cnt_d    = '0;
`ifdef SERIAL_SUB_ABS_DIFF_EN
          state_d  = dig_bout ? S_NEG : S_DONE;
`else
          state_d  = S_DONE;
`endif
        end
      end

      S_NEG: begin
        d_d      = (d_q >> DIGIT) | (WIDTH'(dig_diff) << (WIDTH - DIGIT));
        borrow_d = dig_bout;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          borrow_d = 1'b0;
          cnt_d    = '0;
          state_d  = S_DONE;
        end
      end

      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      d_q      <= '0;
      borrow_q <= 1'b0;
      bout_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      d_q      <= d_d;
      borrow_q <= borrow_d;
      bout_q   <= bout_d;
      cnt_q    <= cnt_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign d         = d_q;
  assign bout      = bout_q;

endmodule

// File: doc/serial_subtractor_n.md
SERIAL_SUBTRACTOR_N -- requirements
Module: serial_subtractor_n

Interface
REQ-001 Parameter WIDTH, default 6: operand/result width in bits.
REQ-002 Parameter DIGIT, default 2: bits processed per cycle; WIDTH % DIGIT == 0 is required, else elaboration error.
REQ-003 clk  input  1  sole clock, rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  operand pair valid.
REQ-006 in_ready  output  1  block can accept operands.
REQ-007 a  input  WIDTH  unsigned minuend.
REQ-008 b  input  WIDTH  unsigned subtrahend.
REQ-009 out_valid  output  1  result valid.
REQ-010 out_ready  input  1  consumer accepts result.
REQ-011 d  output  WIDTH  difference.
REQ-012 bout  output  1  final borrow; 1 iff a < b.

Function
REQ-013 Let N = WIDTH/DIGIT; FSM states are IDLE, RUN, NEG, DONE.
REQ-014 IDLE: in_ready=1 and out_valid=0; in_valid&&in_ready latches a, b, clears borrow and digit counter, and moves to RUN.
REQ-015 RUN: each cycle subtracts digit k (LSB first) as a_k - b_k - borrow, stores the DIGIT-bit result in d slice k, updates borrow, and increments k.
REQ-016 After digit N-1, the FSM goes to DONE; bout = final borrow; d = (a - b) mod 2^WIDTH.
REQ-017 Accept at edge t gives out_valid=1 from edge t+N (t+2N when NEG runs).
REQ-018 DONE: out_valid=1 and in_ready=0; d and bout hold stable until out_valid&&out_ready, then the FSM returns to IDLE.
REQ-019 in_ready is 1 only in IDLE; no operand accept overlaps a result handshake; throughput is one result per N+2 cycles minimum.
REQ-020 in_valid in RUN/NEG/DONE is ignored; a, b changes after accept do not affect the result.
REQ-021 a == b gives d=0 and bout=0; a=0, b=2^WIDTH-1 gives d=1 and bout=1.

Reset
REQ-022 rst_n low forces, asynchronously: state IDLE, d=0, bout=0, borrow=0, counter=0, out_valid=0, and in_ready=1 once released.
REQ-023 Reset in RUN, NEG or DONE discards the transaction; no out_valid is produced for it.

Configuration
REQ-024 Macro SERIAL_SUB_ABS_DIFF_EN: when defined and RUN ends with bout=1, the FSM enters NEG for N cycles computing d = 0 - d digit-serially, then goes to DONE; d = |a - b| and bout stays 1.
REQ-025 Without SERIAL_SUB_ABS_DIFF_EN, NEG is never entered and d is the modular difference.

Structure
REQ-026 Shared package sub_pkg holds the FSM state enum, the N/counter-width derivation function, and the DIGIT-divisibility check.
REQ-027 One sub-module, digit_sub: combinational DIGIT-bit subtractor (x, y, bin -> diff, bout); instantiated once and shared by RUN and NEG through an operand mux.

Verification
REQ-028 WIDTH=6, DIGIT=2, a=42, b=15 -> d=27, bout=0, out_valid 3 cycles after accept.
REQ-029 a=15, b=42 -> d=37, bout=1 at 3 cycles; with SERIAL_SUB_ABS_DIFF_EN -> d=27, bout=1 at 6 cycles.
REQ-030 a=b=63 -> d=0, bout=0; a=0, b=63 -> d=1, bout=1.
REQ-031 out_ready held low 5 cycles in DONE -> d and bout stable, in_ready=0, in_valid ignored; first handshake returns to IDLE.
REQ-032 rst_n pulsed low mid-RUN -> out_valid=0 immediately, in_ready=1 after release, next transaction correct.
REQ-033 WIDTH=8, DIGIT=1, a=200, b=55 -> d=145, bout=0 at 8 cycles.
